checkpoint_recovery_ctrl: RTL and testbench

// - Branch-resolution front end of the checkpoint store.
// - Takes resolved branches from the execute units and emits per-slot validate strobes for correctly predicted branches.
// - Selects the oldest mispredict, drives recall of its checkpoint and unpacks the recalled line.
// - Restores RMT, free-list front, active-list front and busy-bit table; redirects fetch and stalls rename until recovery ends.

---
 rtl/checkpoint_recovery_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_checkpoint_recovery_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_recovery_ctrl.sv
// ----------------------------------------------------------------------------
// checkpoint_recovery_ctrl
//
// Purpose:
//   Branch-resolution front end of the checkpoint store. Correctly predicted
//   branches produce per-slot validate strobes one cycle later. The oldest
//   mispredict is latched and starts a recovery sequence:
//     RECALL  (1 cycle)  : recall the checkpoint line and register it
//     RESTORE (1 cycle)  : restore pulse plus fetch redirect
//     DRAIN   (DRAIN_CYCLES cycles) : keep rename stalled
//   An older mispredict that arrives during recovery restarts it. A younger
//   or equal one is dropped.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   res_*_i               per-slot branch resolutions (valid, id, mispredict, target)
//   cp_front_i            next checkpoint slot to be written (age reference)
//   recalled_data_i       asynchronously read checkpoint line
//   validate_o / validated_id_o   retire permission for correct branches
//   recall_checkpoint_o / recall_id_o   checkpoint recall strobe and id
//   restore_*_o           unpacked checkpoint fields, valid with restore_valid_o
//   redirect_valid_o / redirect_pc_o    fetch redirect
//   flush_stall_o         rename/dispatch hold, low only when idle
//
// Optional build macro RECOVERY_PERF_EN adds saturating performance counters
// perf_mispredicts_o and perf_stall_cycles_o.
// ----------------------------------------------------------------------------
module checkpoint_recovery_ctrl #(
  parameter int NUM_CP       = 8,
  parameter int NUM_RES      = 2,
  parameter int NUM_PR       = 64,
  parameter int AL_SIZE      = 32,
  parameter int DRAIN_CYCLES = 2,
  localparam int CPW       = $clog2(NUM_CP),
  localparam int PRW       = $clog2(NUM_PR),
  localparam int ALW       = $clog2(AL_SIZE),
  localparam int LINE_SIZE = ALW + PRW + 32*PRW + 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_RES-1:0]     res_valid_i,
  input  logic [NUM_RES*CPW-1:0] res_cp_id_i,
  input  logic [NUM_RES-1:0]     res_mispredict_i,
  input  logic [NUM_RES*32-1:0]  res_target_i,
  input  logic [CPW-1:0]         cp_front_i,
  input  logic [LINE_SIZE-1:0]   recalled_data_i,
  output logic [NUM_RES-1:0]     validate_o,
  output logic [NUM_RES*CPW-1:0] validated_id_o,
  output logic                   recall_checkpoint_o,
  output logic [CPW-1:0]         recall_id_o,
  output logic                   restore_valid_o,
  output logic [PRW-1:0]         restore_fl_front_o,
  output logic [ALW-1:0]         restore_al_front_o,
  output logic [NUM_PR-1:0]      restore_bbt_o,
  output logic [32*PRW-1:0]      restore_rmt_o,
  output logic                   redirect_valid_o,
  output logic [31:0]            redirect_pc_o,
  output logic                   flush_stall_o
`ifdef RECOVERY_PERF_EN
  ,
  output logic [31:0]            perf_mispredicts_o,
  output logic [31:0]            perf_stall_cycles_o
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECALL  = 2'd1;
  localparam logic [1:0] ST_RESTORE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  // Distance back from the most recently allocated checkpoint; wraps mod NUM_CP.
  function automatic logic [CPW-1:0] age_f(input logic [CPW-1:0] front,
                                           input logic [CPW-1:0] id);
    age_f = front - {{(CPW-1){1'b0}}, 1'b1} - id;
  endfunction

  logic [1:0]             state_q, state_d;
  logic [CPW-1:0]         pend_id_q, pend_id_d;
  logic [31:0]            pend_pc_q, pend_pc_d;
  logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
  logic [LINE_SIZE-1:0]   line_q;
  logic [NUM_RES-1:0]     validate_q, validate_d;
  logic [NUM_RES*CPW-1:0] validated_id_q;
  logic                   recall_q;
  logic [CPW-1:0]         recall_id_q;
  logic                   restore_q;
  logic [31:0]            redirect_pc_q;
  logic                   flush_q;

  logic                   mp_found_s;
  logic [CPW-1:0]         mp_id_s;
  logic [31:0]            mp_pc_s;
  logic [CPW-1:0]         mp_age_s;
  logic [CPW-1:0]         pend_age_s;
  logic                   take_s;

  // Oldest valid mispredict this cycle; strict compare keeps the lower slot on ties.
  always_comb begin
    logic           better;
    logic [CPW-1:0] a;
    mp_found_s = 1'b0;
    mp_id_s    = '0;
    mp_pc_s    = '0;
    mp_age_s   = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      a          = age_f(cp_front_i, res_cp_id_i[i*CPW +: CPW]);
      better     = res_valid_i[i] & res_mispredict_i[i] & (~mp_found_s | (a > mp_age_s));
      mp_id_s    = better ? res_cp_id_i[i*CPW +: CPW] : mp_id_s;
      mp_pc_s    = better ? res_target_i[i*32 +: 32]  : mp_pc_s;
      mp_age_s   = better ? a                         : mp_age_s;
      mp_found_s = mp_found_s | better;
    end
  end

  // Correct resolutions validate unless they are younger than (or equal to) the pending recall.
  always_comb begin
    logic pass;
    pend_age_s = age_f(cp_front_i, pend_id_q);
    validate_d = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      pass = (state_q == ST_IDLE) |
             (age_f(cp_front_i, res_cp_id_i[i*CPW +: CPW]) > pend_age_s);
      validate_d[i] = res_valid_i[i] & ~res_mispredict_i[i] & pass;
    end
  end

  // Recovery sequencer; an older mispredict takes priority over normal progress.
  always_comb begin
    state_d     = state_q;
    pend_id_d   = pend_id_q;
    pend_pc_d   = pend_pc_q;
    drain_cnt_d = drain_cnt_q;
    take_s      = mp_found_s & ((state_q == ST_IDLE) | (mp_age_s > pend_age_s));
    if (take_s) begin
      state_d   = ST_RECALL;
      pend_id_d = mp_id_s;
      pend_pc_d = mp_pc_s;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_IDLE;
        ST_RECALL:  state_d = ST_RESTORE;
        ST_RESTORE: begin
          state_d     = ST_DRAIN;
          drain_cnt_d = DRAIN_LAST;
        end
        ST_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            drain_cnt_d = drain_cnt_q - {{(DCW-1){1'b0}}, 1'b1};
          end
        end
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // State, pending branch, recalled line and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pend_id_q      <= '0;
      pend_pc_q      <= '0;
      drain_cnt_q    <= '0;
      line_q         <= '0;
      validate_q     <= '0;
      validated_id_q <= '0;
      recall_q       <= 1'b0;
      recall_id_q    <= '0;
      restore_q      <= 1'b0;
      redirect_pc_q  <= '0;
      flush_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_id_q      <= pend_id_d;
      pend_pc_q      <= pend_pc_d;
      drain_cnt_q    <= drain_cnt_d;
      line_q         <= (state_q == ST_RECALL) ? recalled_data_i : line_q;
      validate_q     <= validate_d;
      validated_id_q <= res_cp_id_i;
      recall_q       <= (state_d == ST_RECALL);
      recall_id_q    <= (state_d == ST_RECALL) ? pend_id_d : '0;
      restore_q      <= (state_d == ST_RESTORE);
      redirect_pc_q  <= (state_d == ST_RESTORE) ? pend_pc_d : 32'd0;
      flush_q        <= (state_d != ST_IDLE);
    end
  end

  assign validate_o          = validate_q;
  assign validated_id_o      = validated_id_q;
  assign recall_checkpoint_o = recall_q;
  assign recall_id_o         = recall_id_q;
  assign restore_valid_o     = restore_q;
  assign redirect_valid_o    = restore_q;
  assign redirect_pc_o       = redirect_pc_q;
  assign flush_stall_o       = flush_q;
  assign restore_fl_front_o  = line_q[PRW-1:0];
  assign restore_al_front_o  = line_q[ALW+PRW-1:PRW];
  assign restore_bbt_o       = line_q[ALW+PRW+NUM_PR-1:ALW+PRW];
  assign restore_rmt_o       = line_q[ALW+PRW+64 +: 32*PRW];

`ifdef RECOVERY_PERF_EN
  logic [31:0] perf_mis_q;
  logic [31:0] perf_stall_q;

  // Saturating counters: recall entries (restarts included) and stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_mis_q   <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_mis_q   <= (take_s && (perf_mis_q != 32'hFFFF_FFFF)) ? perf_mis_q + 32'd1 : perf_mis_q;
      perf_stall_q <= (flush_q && (perf_stall_q != 32'hFFFF_FFFF)) ? perf_stall_q + 32'd1 : perf_stall_q;
    end
  end

  assign perf_mispredicts_o  = perf_mis_q;
  assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_checkpoint_recovery_ctrl.sv
// ----------------------------------------------------------------------------
// tb_checkpoint_recovery_ctrl
//
// Directed scenarios followed by randomized resolutions, all checked against a
// reference model that tracks recovery as "cycles left in recovery" plus the
// pending branch, and a table of checkpoint lines served to the recall port.
// ----------------------------------------------------------------------------
module tb_checkpoint_recovery_ctrl;

  localparam int CPW  = 3;
  localparam int PRW  = 6;
  localparam int ALW  = 5;
  localparam int LS   = ALW + PRW + 32*PRW + 64;
  localparam int DRN  = 2;
  localparam int L    = 2 + DRN;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        res_valid;
  logic [2*CPW-1:0]  res_cp_id;
  logic [1:0]        res_mispredict;
  logic [63:0]       res_target;
  logic [CPW-1:0]    cp_front;
  logic [LS-1:0]     recalled_data;
  logic [1:0]        validate;
  logic [2*CPW-1:0]  validated_id;
  logic              recall_checkpoint;
  logic [CPW-1:0]    recall_id;
  logic              restore_valid;
  logic [PRW-1:0]    restore_fl_front;
  logic [ALW-1:0]    restore_al_front;
  logic [63:0]       restore_bbt;
  logic [32*PRW-1:0] restore_rmt;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              flush_stall;
`ifdef RECOVERY_PERF_EN
  logic [31:0]       perf_mispredicts;
  logic [31:0]       perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  checkpoint_recovery_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .res_valid_i         (res_valid),
    .res_cp_id_i         (res_cp_id),
    .res_mispredict_i    (res_mispredict),
    .res_target_i        (res_target),
    .cp_front_i          (cp_front),
    .recalled_data_i     (recalled_data),
    .validate_o          (validate),
    .validated_id_o      (validated_id),
    .recall_checkpoint_o (recall_checkpoint),
    .recall_id_o         (recall_id),
    .restore_valid_o     (restore_valid),
    .restore_fl_front_o  (restore_fl_front),
    .restore_al_front_o  (restore_al_front),
    .restore_bbt_o       (restore_bbt),
    .restore_rmt_o       (restore_rmt),
    .redirect_valid_o    (redirect_valid),
    .redirect_pc_o       (redirect_pc),
    .flush_stall_o       (flush_stall)
`ifdef RECOVERY_PERF_EN
    ,
    .perf_mispredicts_o  (perf_mispredicts),
    .perf_stall_cycles_o (perf_stall_cycles)
`endif
  );

  // Checkpoint store: asynchronous read while recall is asserted.
  logic [LS-1:0] cp_mem [8];
  logic [LS-1:0] junk_line;
  always_comb recalled_data = recall_checkpoint ? cp_mem[recall_id] : junk_line;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_left;
  int          m_pend;
  logic [31:0] m_pc;
  logic [1:0]  e_val;
  logic [5:0]  e_vid;
  logic [31:0] m_mis;
  logic [31:0] m_stall;

  function automatic int age(input int front, input int id);
    return (((front - 1 - id) % 8) + 8) % 8;
  endfunction

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_left  = 0;
    m_pend  = 0;
    m_pc    = 32'd0;
    e_val   = 2'b00;
    e_vid   = 6'd0;
    m_mis   = 32'd0;
    m_stall = 32'd0;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    int best, bage, a, id;
    if (reset) begin
      model_reset();
      return;
    end
    best = -1;
    bage = -1;
    for (int i = 0; i < 2; i++) begin
      id = int'(res_cp_id[i*CPW +: CPW]);
      a  = age(int'(cp_front), id);
      e_val[i] = res_valid[i] && !res_mispredict[i] &&
                 (m_left == 0 || a > age(int'(cp_front), m_pend));
      if (res_valid[i] && res_mispredict[i] && a > bage) begin
        best = i;
        bage = a;
      end
    end
    e_vid = res_cp_id;
    if (m_left != 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (best >= 0 && (m_left == 0 || bage > age(int'(cp_front), m_pend))) begin
      m_pend = int'(res_cp_id[best*CPW +: CPW]);
      m_pc   = res_target[best*32 +: 32];
      m_left = L;
      if (m_mis != 32'hFFFF_FFFF) m_mis++;
    end else if (m_left > 0) begin
      m_left--;
    end
  endtask

  task automatic check_all();
    logic [LS-1:0] ln;
    chk("validate", validate, e_val);
    chk("validated_id", validated_id, e_vid);
    chk("recall", recall_checkpoint, m_left == L);
    if (m_left == L) chk("recall_id", recall_id, m_pend);
    chk("restore_valid", restore_valid, m_left == L - 1);
    chk("redirect_valid", redirect_valid, m_left == L - 1);
    if (m_left == L - 1) begin
      ln = cp_mem[m_pend];
      chk("redirect_pc", redirect_pc, m_pc);
      chk("fl_front", restore_fl_front, ln[PRW-1:0]);
      chk("al_front", restore_al_front, ln[ALW+PRW-1:PRW]);
      chk("bbt", restore_bbt, ln[ALW+PRW+64-1:ALW+PRW]);
      chk("rmt", restore_rmt, ln[ALW+PRW+64 +: 32*PRW]);
    end
    chk("flush_stall", flush_stall, m_left != 0);
`ifdef RECOVERY_PERF_EN
    chk("perf_mis", perf_mispredicts, m_mis);
    chk("perf_stall", perf_stall_cycles, m_stall);
`endif
  endtask

  task automatic do_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_in();
    res_valid      = 2'b00;
    res_mispredict = 2'b00;
    res_cp_id      = 6'd0;
    res_target     = 64'd0;
  endtask

  task automatic set_slot(input int s, input logic mp, input logic [CPW-1:0] id,
                          input logic [31:0] tgt);
    res_valid[s]            = 1'b1;
    res_mispredict[s]       = mp;
    res_cp_id[s*CPW +: CPW] = id;
    res_target[s*32 +: 32]  = tgt;
  endtask

  initial begin
    logic [LS-1:0] w;
    int fc;
    for (int k = 0; k < 8; k++) begin
      w = '0;
      for (int j = 0; j < 9; j++) w = (w << 32) | LS'($urandom());
      cp_mem[k] = w;
    end
    junk_line = {LS{1'b1}};
    clear_in();
    cp_front = 3'd0;
    reset    = 1'b1;
    model_reset();
    do_cycle();
    do_cycle();
    chk("rst_recall_id", recall_id, 3'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_bbt", restore_bbt, 64'd0);
    chk("rst_rmt", restore_rmt, 192'd0);
    reset = 1'b0;

    // Correct-path resolve of ids 3 and 4.
    cp_front = 3'd5;
    set_slot(0, 1'b0, 3'd3, 32'h0);
    set_slot(1, 1'b0, 3'd4, 32'h0);
    do_cycle();
    chk("cp_validate", validate, 2'b11);
    chk("cp_validated_id", validated_id, {3'd4, 3'd3});
    chk("cp_no_stall", flush_stall, 1'b0);
    clear_in();

    // Single mispredict: recall, restore/redirect, 4 stalled cycles.
    cp_front = 3'd5;
    set_slot(0, 1'b1, 3'd2, 32'h0000_1000);
    do_cycle();
    chk("sm_recall", recall_checkpoint, 1'b1);
    chk("sm_recall_id", recall_id, 3'd2);
    fc = int'(flush_stall);
    clear_in();
    do_cycle();
    chk("sm_restore", restore_valid, 1'b1);
    chk("sm_redirect", redirect_valid, 1'b1);
    chk("sm_redirect_pc", redirect_pc, 32'h0000_1000);
    fc += int'(flush_stall);
    for (int k = 0; k < 4; k++) begin
      do_cycle();
      fc += int'(flush_stall);
    end
    chk("sm_flush_len", fc, 4);

    // Dual mispredict across the wrap: id 7 is older than id 0.
    cp_front = 3'd1;
    set_slot(0, 1'b1, 3'd7, 32'h0000_7777);
    set_slot(1, 1'b1, 3'd0, 32'h0000_0000);
    do_cycle();
    chk("dual_recall_id", recall_id, 3'd7);
    clear_in();
    for (int k = 0; k < 4; k++) do_cycle();

    // Restart from DRAIN by older id 3; concurrent id 5 dropped.
    cp_front = 3'd6;
    set_slot(0, 1'b1, 3'd5, 32'h0000_5555);
    do_cycle();
    chk("rs_recall_id5", recall_id, 3'd5);
    clear_in();
    do_cycle();
    do_cycle();
    chk("rs_in_drain", flush_stall & ~restore_valid & ~recall_checkpoint, 1'b1);
    set_slot(0, 1'b1, 3'd5, 32'h0000_5005);
    set_slot(1, 1'b1, 3'd3, 32'h0000_3333);
    do_cycle();
    chk("rs_recall", recall_checkpoint, 1'b1);
    chk("rs_recall_id3", recall_id, 3'd3);
    clear_in();
    do_cycle();
    chk("rs_redirect_pc", redirect_pc, 32'h0000_3333);
    for (int k = 0; k < 3; k++) do_cycle();

    // Filtered validate during RESTORE of id 4.
    cp_front = 3'd6;
    set_slot(0, 1'b1, 3'd4, 32'h0000_4444);
    do_cycle();
    clear_in();
    do_cycle();
    chk("fv_in_restore", restore_valid, 1'b1);
    set_slot(0, 1'b0, 3'd2, 32'h0);
    set_slot(1, 1'b0, 3'd5, 32'h0);
    do_cycle();
    chk("fv_validate", validate, 2'b01);
    chk("fv_validated_id0", validated_id[2:0], 3'd2);
    clear_in();
    for (int k = 0; k < 3; k++) do_cycle();

    // Reset mid-recovery: no restore/redirect pulse afterwards.
    cp_front = 3'd2;
    set_slot(0, 1'b1, 3'd0, 32'h0000_ABCD);
    do_cycle();
    clear_in();
    reset = 1'b1;
    do_cycle();
    chk("rr_no_redirect", redirect_valid, 1'b0);
    chk("rr_no_restore", restore_valid, 1'b0);
    chk("rr_no_stall", flush_stall, 1'b0);
    reset = 1'b0;
    do_cycle();
    chk("rr_still_idle", redirect_valid | flush_stall, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      cp_front = 3'($urandom_range(0, 7));
      for (int s = 0; s < 2; s++) begin
        res_valid[s]            = 1'($urandom_range(0, 1));
        res_mispredict[s]       = ($urandom_range(0, 9) == 0);
        res_cp_id[s*CPW +: CPW] = 3'($urandom_range(0, 7));
        res_target[s*32 +: 32]  = $urandom();
      end
      reset = ($urandom_range(0, 149) == 0);
      do_cycle();
    end
    reset = 1'b0;
    clear_in();
    do_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
